// File: rtl/lms_tdm.sv
// Time-multiplexed LMS coefficient updater: one shared MAC writes one tap per cycle, N_COEF+1 cycles per sample.
// Not flow-controlled: i_valid while busy is dropped and flagged on o_overrun; o_coefs is combinational from the tap registers.
module lms_tdm #(
    parameter int DATA_BW    = 11,
    parameter int DATA_FBW   = 7,
    parameter int ERR_BW     = 8,
    parameter int ACC_BW     = 25,
    parameter int COEF_BW    = 9,
    parameter int COEF_FBW   = 7,
    parameter int N_COEF     = 7,
    parameter int CENTER     = 3,
    parameter int LEAK_SHIFT = 0
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_valid,
    input  logic [DATA_BW-1:0]          i_data,
    input  logic [ERR_BW-1:0]           i_error,
    input  logic [ERR_BW-1:0]           i_mu,
    input  logic                        i_freeze,
    input  logic                        i_clr,
    output logic [COEF_BW*N_COEF-1:0]   o_coefs,
    output logic                        o_busy,
    output logic                        o_done,
    output logic                        o_overrun
);

    localparam int ACC_FBW = 2*(ERR_BW-1) + DATA_FBW;
    localparam int PW      = 2*ERR_BW;
    localparam int MW      = PW + DATA_BW;
    localparam int SW      = ((ACC_BW > MW) ? ACC_BW : MW) + 2;
    localparam int LO      = ACC_FBW - COEF_FBW;
    localparam int HI      = LO + COEF_BW - 1;
    localparam int KW      = (N_COEF > 1) ? $clog2(N_COEF) : 1;

    localparam logic [KW-1:0]      K_LAST    = KW'(N_COEF-1);
    localparam logic [ACC_BW-1:0]  C_ONE     = ACC_BW'(1) << ACC_FBW;
    localparam logic [ACC_BW-1:0]  ACC_MAX   = {1'b0, {(ACC_BW-1){1'b1}}};
    localparam logic [ACC_BW-1:0]  ACC_MIN   = {1'b1, {(ACC_BW-1){1'b0}}};
    localparam logic [COEF_BW-1:0] COEF_MAX  = {1'b0, {(COEF_BW-1){1'b1}}};
    localparam logic [COEF_BW-1:0] COEF_MIN  = {1'b1, {(COEF_BW-1){1'b0}}};

    typedef enum logic {S_IDLE, S_UPD} state_t;

    state_t                     state_q, state_d;
    logic signed [DATA_BW-1:0]  dl_q [N_COEF];
    logic signed [ACC_BW-1:0]   c_q  [N_COEF];
    logic signed [PW-1:0]       p_q;
    logic [KW-1:0]              k_q;
    logic                       done_q;
    logic                       ovr_q;

    logic signed [ACC_BW-1:0]   c_cur;
    logic signed [ACC_BW-1:0]   leak;
    logic signed [ACC_BW-1:0]   c_nxt;
    logic signed [MW-1:0]       corr;
    logic [SW-1:0]              sum;

    // Shared MAC: p carries 2*(ERR_BW-1) fraction bits, so p*dl already lands on ACC_FBW.
    always_comb begin
        c_cur = c_q[k_q];
        corr  = p_q * dl_q[k_q];
        leak  = (LEAK_SHIFT > 0) ? (c_cur >>> LEAK_SHIFT) : '0;
        sum   = {{(SW-ACC_BW){c_cur[ACC_BW-1]}}, c_cur}
              - {{(SW-ACC_BW){leak[ACC_BW-1]}}, leak}
              + {{(SW-MW){corr[MW-1]}}, corr};
        if ((&sum[SW-1:ACC_BW-1]) || (~|sum[SW-1:ACC_BW-1]))
            c_nxt = sum[ACC_BW-1:0];
        else
            c_nxt = sum[SW-1] ? ACC_MIN : ACC_MAX;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (i_valid && !i_freeze) state_d = S_UPD;
            S_UPD:  if (k_q == K_LAST) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (i_clr)
            state_d = S_IDLE;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            p_q     <= '0;
            done_q  <= 1'b0;
            ovr_q   <= 1'b0;
            for (int i = 0; i < N_COEF; i++) begin
                dl_q[i] <= '0;
                c_q[i]  <= (i == CENTER) ? C_ONE : '0;
            end
        end else begin
            state_q <= state_d;
            done_q  <= 1'b0;
            ovr_q   <= 1'b0;
            if (i_clr) begin
                k_q <= '0;
                for (int i = 0; i < N_COEF; i++) begin
                    dl_q[i] <= '0;
                    c_q[i]  <= (i == CENTER) ? C_ONE : '0;
                end
            end else if (state_q == S_IDLE) begin
                if (i_valid) begin
                    for (int i = N_COEF-1; i > 0; i--)
                        dl_q[i] <= dl_q[i-1];
                    dl_q[0] <= $signed(i_data);
                    if (!i_freeze) begin
                        p_q <= $signed(i_error) * $signed(i_mu);
                        k_q <= '0;
                    end
                end
            end else begin
                c_q[k_q] <= c_nxt;
                k_q      <= k_q + KW'(1);
                if (k_q == K_LAST)
                    done_q <= 1'b1;
                if (i_valid)
                    ovr_q <= 1'b1;
            end
        end
    end

    // Floor-truncate each tap to the output format, clamping when the dropped MSBs carry magnitude.
    always_comb begin
        o_coefs = '0;
        for (int k = 0; k < N_COEF; k++) begin
            if ((&c_q[k][ACC_BW-1:HI]) || (~|c_q[k][ACC_BW-1:HI]))
                o_coefs[COEF_BW*k +: COEF_BW] = c_q[k][HI:LO];
            else
                o_coefs[COEF_BW*k +: COEF_BW] = c_q[k][ACC_BW-1] ? COEF_MIN : COEF_MAX;
        end
    end

    assign o_busy    = (state_q == S_UPD);
    assign o_done    = done_q;
    assign o_overrun = ovr_q;

endmodule

// File: doc/lms_tdm.md
# lms_tdm

Time-multiplexed, parametrised LMS coefficient updater for the adaptive FIR equalizer. It is the successor to the fully parallel updater: one shared multiply-accumulate path updates one tap per cycle under a small FSM. It adds configurable formats, tap count and centre tap, optional coefficient leakage, a freeze input, a soft clear, and busy/done/overrun handshakes. It sits beside the equalizer FIR and feeds it `o_coefs`.

## Interface
- `DATA_BW`, 11: input data width, signed.
- `DATA_FBW`, 7: input data fractional bits.
- `ERR_BW`, 8: error and step-size width (`i_error` and `i_mu`), fractional bits = `ERR_BW-1`.
- `ACC_BW`, 25: coefficient accumulator width; fractional bits `ACC_FBW = 2*(ERR_BW-1)+DATA_FBW` (21 by default).
- `COEF_BW`, 9: output coefficient width.
- `COEF_FBW`, 7: output coefficient fractional bits.
- `N_COEF`, 7: number of taps.
- `CENTER`, 3: tap initialised to 1.0.
- `LEAK_SHIFT`, 0: leakage shift; 0 disables leakage.

Ports:
- `i_clk` in 1: clock.
- `i_rst` in 1: reset, asynchronous, active-high.
- `i_valid` in 1: sample strobe.
- `i_data` in `DATA_BW`: x(n).
- `i_error` in `ERR_BW`: e(n).
- `i_mu` in `ERR_BW`: step size.
- `i_freeze` in 1: accept the sample but skip adaptation.
- `i_clr` in 1: synchronous soft clear.
- `o_coefs` out `COEF_BW*N_COEF`: {C[N-1] … C[0]}, C[k] at bits `[COEF_BW*(k+1)-1 : COEF_BW*k]`.
- `o_busy` out 1: update in progress.
- `o_done` out 1: one-cycle pulse when all taps have been updated.
- `o_overrun` out 1: one-cycle pulse when `i_valid` arrives while busy.

## Operation
- Delay line `dl[0..N_COEF-1]`, where `dl[0]` is the newest accepted sample.
- FSM states:
  - **IDLE**: on `i_valid`, shift `i_data` into `dl`.
    - If `i_freeze=0`: register `p = i_error*i_mu` (width `2*ERR_BW`, full precision), set k=0, and go to **UPD**.
    - If `i_freeze=1`: stay in IDLE; coefficients are unchanged.
  - **UPD**: each cycle, write tap k with c[k] ← sat(c[k] − leak(c[k]) + p*dl[k]), then k++.
    - After tap N_COEF-1 is written, return to IDLE.
- Arithmetic rules:
  - The correction term `p*dl[k]` is full precision with `ACC_FBW` fractional bits, so no alignment shift is needed.
  - `leak(c)` = `c >>> LEAK_SHIFT` (arithmetic shift, floor) when `LEAK_SHIFT>0`, else 0.
  - The sum is formed at max(`ACC_BW`, product width)+2 bits.
  - The result saturates to [−2^(ACC_BW−1), 2^(ACC_BW−1)−1].
- Output mapping: C[k] = c[k] bits [`ACC_FBW−COEF_FBW+COEF_BW−1` : `ACC_FBW−COEF_FBW`] (truncate, floor).
  - If the discarded upper bits are not a pure sign extension, saturate to +2^(COEF_BW−1)−1 or −2^(COEF_BW−1).
  - This path is combinational from the coefficient registers.
- `i_valid` while `o_busy=1`: the sample is dropped, `dl` is unchanged, `o_overrun` pulses, and the update in progress continues.
- `i_clr` has top priority, in any state:
  - coefficients return to reset values, `dl` is zeroed, FSM goes to IDLE;
  - an update in progress is aborted with no `o_done`;
  - a simultaneous `i_valid` is ignored.
- `i_freeze` is sampled only when a sample is accepted; it has no effect mid-update.

## Timing
- Reset (asynchronous) values:
  - c[CENTER] = 1.0 (`1<<ACC_FBW`), all other taps 0;
  - `dl` all 0, FSM IDLE;
  - outputs: `o_busy`=0, `o_done`=0, `o_overrun`=0;
  - `o_coefs`: C[CENTER] = `1<<COEF_FBW` (0x080 by default), others 0.
- Accept edge E0 (IDLE and `i_valid`): `dl` and `p` are registered, and `o_busy` is 1 from E0.
- Tap k is written at edge E(k+1).
- At edge E(N_COEF), after the last tap write: `o_busy`→0 and `o_done`→1 for exactly one cycle.
- A new `i_valid` can be accepted in the `o_done` cycle. Sustained throughput is one sample per N_COEF+1 cycles.
- `o_overrun` is registered and asserted at the edge that samples the offending `i_valid`.
- Assertion of `i_rst` mid-update aborts immediately; release requires no extra cycles.

## Test plan
- **Reset:** assert `i_rst` asynchronously mid-cycle → `o_coefs` = 0x080 at C3, 0 elsewhere; `o_busy`, `o_done` and `o_overrun` are 0 with no clock edge.
- **Single update (defaults):** `i_mu`=64 (0.5), `i_error`=32 (0.25), `i_data`=128 (1.0) → C0=16 (0.125) and other taps unchanged. `o_busy` is high for 7 cycles and `o_done` pulses at E7.
- **Saturation:** repeated `i_valid` with `i_error`=127, `i_mu`=127, `i_data`=1023 → c[0] pegs at 2^24−1 with no wrap and C0 = 255. The opposite sign of `i_error` pegs at −2^24 with C0 = −256.
- **Overrun/freeze:**
  - `i_valid` at cycle E3 of an update → `o_overrun` pulses, `dl` is unchanged, and `o_done` still occurs at E7.
  - `i_freeze`=1 with nonzero error → `dl` shifts, coefficients are unchanged, and no busy or done.
- **Clear mid-update:** `i_clr` at E4 → coefficients return to reset values the next cycle, no `o_done`, and the next `i_valid` is accepted normally.
- **Leakage:** `LEAK_SHIFT`=4, `i_error`=0, one sample → C3 = 120 (1.0 − 1/16).
